// File: rtl/sysctrl_pkg.sv
// Shared definitions for the MCU system-control endpoint: command codes,
// reply magic bytes, counter widths and a byte bit-reversal helper.
package sysctrl_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 8;

    localparam logic [7:0] MAGIC0 = 8'h5C;
    localparam logic [7:0] MAGIC1 = 8'h42;

    typedef enum logic [7:0] {
        CMD_STATUS   = 8'd0,
        CMD_LEDS     = 8'd1,
        CMD_COLOR    = 8'd2,
        CMD_BUTTONS  = 8'd3,
        CMD_CFG_WR   = 8'd4,
        CMD_IRQ_ACK  = 8'd5,
        CMD_IRQ_MASK = 8'd6,
        CMD_CFG_RD   = 8'd7
    } cmd_e;

    // The MCU link sends colour bytes LSB-first relative to the colour bus.
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sysctrl_irq.sv
// Interrupt controller: registered inputs, rising-edge latched pending bits,
// mask register, acknowledge pulses and the active-low request line.
module sysctrl_irq
    import sysctrl_pkg::*;
#(
    parameter int unsigned NUM_INT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_INT-1:0] int_in,
    input  logic               ack_we,
    input  logic [NUM_INT-1:0] ack_bits,
    input  logic               mask_we,
    input  logic [NUM_INT-1:0] mask_data,
    output logic [NUM_INT-1:0] pending,
    output logic [NUM_INT-1:0] int_ack,
    output logic               int_out_n
);

    logic [NUM_INT-1:0] int_q;
    logic [NUM_INT-1:0] int_prev;
    logic [NUM_INT-1:0] mask;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] clr;

    assign rise = int_q & ~int_prev;
    assign clr  = ack_we ? (ack_bits & pending) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            int_q    <= '0;
            int_prev <= '0;
            pending  <= '0;
            mask     <= '1;
            int_ack  <= '0;
        end else begin
            int_q    <= int_in;
            int_prev <= int_q;
            // a new edge outranks a simultaneous acknowledge
            pending  <= (pending & ~clr) | rise;
            int_ack  <= clr;
            if (mask_we) begin
                mask <= mask_data;
            end
        end
    end

    assign int_out_n = ~|(pending & mask);

endmodule

// File: rtl/sysctrl_gen.sv
// MCU byte-stream frame decoder: status, LEDs, colour, buttons, an indexed
// config register file and the interrupt controller front-end.
module sysctrl_gen
    import sysctrl_pkg::*;
#(
    parameter logic [7:0]            CORE_ID     = 8'h01,
    parameter int unsigned           NUM_LEDS    = 2,
    parameter int unsigned           NUM_BUTTONS = 2,
    parameter int unsigned           NUM_INT     = 8,
    parameter int unsigned           NUM_CFG     = 16,
    parameter logic [NUM_CFG*8-1:0]  CFG_DEFAULT = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_in_strobe,
    input  logic                   data_in_start,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   int_out_n,
    input  logic [NUM_INT-1:0]     int_in,
    output logic [NUM_INT-1:0]     int_ack,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_LEDS-1:0]    leds,
    output logic [23:0]            color,
    output logic [NUM_CFG*8-1:0]   cfg_values,
    output logic [NUM_CFG-1:0]     cfg_strobe
);

    cmd_e             command;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             byte_ok;
    logic [7:0]       rd_byte;
    logic [NUM_INT-1:0] pending;

    assign byte_ok = data_in_strobe && !data_in_start && (cnt != '0);

    // out-of-range indices read as zero
    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < NUM_CFG; i++) begin
            if (32'(idx) == i) begin
                rd_byte = cfg_values[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            command    <= CMD_STATUS;
            cnt        <= '0;
            idx        <= '0;
            leds       <= '0;
            color      <= '0;
            cfg_values <= CFG_DEFAULT;
            cfg_strobe <= '0;
            data_out   <= '0;
        end else begin
            cfg_strobe <= '0;
            if (data_in_strobe && data_in_start) begin
                command <= cmd_e'(data_in);
                cnt     <= CNT_W'(1);
            end else if (byte_ok) begin
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
                case (command)
                    CMD_STATUS: begin
                        case (cnt)
                            CNT_W'(1): data_out <= MAGIC0;
                            CNT_W'(2): data_out <= MAGIC1;
                            CNT_W'(3): data_out <= CORE_ID;
                            CNT_W'(4): data_out <= 8'(NUM_CFG);
                            default: ;
                        endcase
                    end
                    CMD_LEDS: begin
                        if (cnt == CNT_W'(1)) leds <= data_in[NUM_LEDS-1:0];
                    end
                    CMD_COLOR: begin
                        case (cnt)
                            CNT_W'(1): color[15:8]  <= bitrev8(data_in);
                            CNT_W'(2): color[7:0]   <= bitrev8(data_in);
                            CNT_W'(3): color[23:16] <= bitrev8(data_in);
                            default: ;
                        endcase
                    end
                    CMD_BUTTONS: data_out <= 8'(buttons);
                    CMD_CFG_WR: begin
                        if (cnt == CNT_W'(1)) begin
                            idx <= data_in;
                        end else begin
                            for (int unsigned i = 0; i < NUM_CFG; i++) begin
                                if (32'(idx) == i) begin
                                    cfg_values[i*8 +: 8] <= data_in;
                                    cfg_strobe[i]        <= 1'b1;
                                end
                            end
                            if (idx != '1) idx <= idx + IDX_W'(1);
                        end
                    end
                    CMD_IRQ_ACK: data_out <= 8'(pending);
                    CMD_CFG_RD: begin
                        if (cnt == CNT_W'(1)) begin
                            idx <= data_in;
                        end else begin
                            data_out <= rd_byte;
                            if (idx != '1) idx <= idx + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sysctrl_irq #(
        .NUM_INT(NUM_INT)
    ) u_irq (
        .clk       (clk),
        .reset     (reset),
        .int_in    (int_in),
        .ack_we    (byte_ok && command == CMD_IRQ_ACK && cnt == CNT_W'(1)),
        .ack_bits  (data_in[NUM_INT-1:0]),
        .mask_we   (byte_ok && command == CMD_IRQ_MASK && cnt == CNT_W'(1)),
        .mask_data (data_in[NUM_INT-1:0]),
        .pending   (pending),
        .int_ack   (int_ack),
        .int_out_n (int_out_n)
    );

endmodule

// File: tb/tb_sysctrl_gen.sv
// Scoreboard bench for sysctrl_gen: stimulus queues expected values with a
// due cycle, an independent monitor compares them on the falling edge.
module tb_sysctrl_gen;

    localparam int unsigned NCFG = 16;
    localparam logic [NCFG*8-1:0] DEF = {96'h0, 32'h3300_005A};

    logic              clk;
    logic              reset;
    logic              data_in_strobe;
    logic              data_in_start;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              int_out_n;
    logic [7:0]        int_in;
    logic [7:0]        int_ack;
    logic [1:0]        buttons;
    logic [1:0]        leds;
    logic [23:0]       color;
    logic [NCFG*8-1:0] cfg_values;
    logic [NCFG-1:0]   cfg_strobe;

    sysctrl_gen #(
        .CORE_ID     (8'h01),
        .NUM_LEDS    (2),
        .NUM_BUTTONS (2),
        .NUM_INT     (8),
        .NUM_CFG     (NCFG),
        .CFG_DEFAULT (DEF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .data_out       (data_out),
        .int_out_n      (int_out_n),
        .int_in         (int_in),
        .int_ack        (int_ack),
        .buttons        (buttons),
        .leds           (leds),
        .color          (color),
        .cfg_values     (cfg_values),
        .cfg_strobe     (cfg_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef enum int {K_DOUT, K_LEDS, K_COLOR, K_STB, K_ACK, K_INTN, K_REG} kind_e;
    typedef struct {
        kind_e       kind;
        int unsigned idx;
        logic [31:0] exp;
        int          due;
        string       name;
    } item_t;

    item_t sb[$];
    int tests  = 0;
    int failed = 0;

    function automatic logic [31:0] actual(kind_e k, int unsigned idx);
        logic [NCFG*8-1:0] sh;
        case (k)
            K_DOUT:  return 32'(data_out);
            K_LEDS:  return 32'(leds);
            K_COLOR: return 32'(color);
            K_STB:   return 32'(cfg_strobe);
            K_ACK:   return 32'(int_ack);
            K_INTN:  return 32'(int_out_n);
            default: begin
                sh = cfg_values >> (8 * idx);
                return 32'(sh[7:0]);
            end
        endcase
    endfunction

    initial forever begin
        item_t keep[$];
        logic [31:0] act;
        @(negedge clk);
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                tests++;
                act = actual(sb[i].kind, sb[i].idx);
                if (act !== sb[i].exp) begin
                    failed++;
                    $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                             sb[i].name, act, sb[i].exp, cyc);
                end
            end else if (sb[i].due < cyc) begin
                tests++;
                failed++;
                $display("FAIL %s: never checked, due cycle %0d", sb[i].name, sb[i].due);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic chk(kind_e k, int unsigned idx, logic [31:0] e, int d, string n);
        item_t it;
        it.kind = k;
        it.idx  = idx;
        it.exp  = e;
        it.due  = cyc + d;
        it.name = n;
        sb.push_back(it);
    endtask

    task automatic send(logic s, logic [7:0] b);
        @(negedge clk);
        data_in_strobe = 1'b1;
        data_in_start  = s;
        data_in        = b;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            data_in_strobe = 1'b0;
            data_in_start  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in = '0;
        int_in  = '0;
        buttons = '0;
        idle(3);
        chk(K_DOUT, 0, 32'h00, 1, "rst_dout");
        chk(K_LEDS, 0, 32'h0, 1, "rst_leds");
        chk(K_COLOR, 0, 32'h0, 1, "rst_color");
        chk(K_STB, 0, 32'h0, 1, "rst_stb");
        chk(K_ACK, 0, 32'h0, 1, "rst_ack");
        chk(K_INTN, 0, 32'h1, 1, "rst_intn");
        chk(K_REG, 0, 32'h5A, 1, "rst_reg0");
        chk(K_REG, 3, 32'h33, 1, "rst_reg3");
        @(negedge clk);
        reset = 1'b0;

        // status frame
        send(1, 8'h00);
        send(0, 8'h00); chk(K_DOUT, 0, 32'h5C, 1, "status_magic0");
        send(0, 8'h00); chk(K_DOUT, 0, 32'h42, 1, "status_magic1");
        send(0, 8'h00); chk(K_DOUT, 0, 32'h01, 1, "status_core_id");
        send(0, 8'h00); chk(K_DOUT, 0, 32'h10, 1, "status_num_cfg");
        idle(1);

        // config write burst
        send(1, 8'h04);
        send(0, 8'h03);
        send(0, 8'hAA); chk(K_STB, 0, 32'h0008, 1, "wr_stb3");
        send(0, 8'hBB); chk(K_STB, 0, 32'h0010, 1, "wr_stb4");
        send(0, 8'hCC); chk(K_STB, 0, 32'h0020, 1, "wr_stb5");
        idle(1);
        chk(K_STB, 0, 32'h0, 1, "wr_stb_idle");
        chk(K_REG, 3, 32'hAA, 1, "wr_reg3");
        chk(K_REG, 4, 32'hBB, 1, "wr_reg4");
        chk(K_REG, 5, 32'hCC, 1, "wr_reg5");
        chk(K_DOUT, 0, 32'h10, 1, "wr_dout_hold");

        // config read burst
        send(1, 8'h07);
        send(0, 8'h03); chk(K_DOUT, 0, 32'h10, 1, "rd_idx_hold");
        send(0, 8'h00); chk(K_DOUT, 0, 32'hAA, 1, "rd_reg3");
        send(0, 8'h00); chk(K_DOUT, 0, 32'hBB, 1, "rd_reg4");
        send(0, 8'h00); chk(K_DOUT, 0, 32'hCC, 1, "rd_reg5");
        send(1, 8'h07);
        send(0, 8'h10);
        send(0, 8'h00); chk(K_DOUT, 0, 32'h00, 1, "rd_idx16_zero");
        idle(1);

        // write at the top of the register file, then overflow
        send(1, 8'h04);
        send(0, 8'h0F);
        send(0, 8'h11); chk(K_STB, 0, 32'h8000, 1, "wr_stb15");
        send(0, 8'h22); chk(K_STB, 0, 32'h0000, 1, "wr_overflow_no_stb");
        idle(1);
        chk(K_REG, 15, 32'h11, 1, "wr_reg15");
        chk(K_REG, 0, 32'h5A, 1, "wr_reg0_untouched");
        send(1, 8'h07);
        send(0, 8'h0F);
        send(0, 8'h00); chk(K_DOUT, 0, 32'h11, 1, "rd_reg15");
        send(0, 8'h00); chk(K_DOUT, 0, 32'h00, 1, "rd_past_end");
        idle(1);

        // colour, LEDs, buttons
        send(1, 8'h02);
        send(0, 8'h01);
        send(0, 8'h02);
        send(0, 8'h80); chk(K_COLOR, 0, 32'h018040, 1, "color");
        send(1, 8'h01);
        send(0, 8'hFE); chk(K_LEDS, 0, 32'h2, 1, "leds");
        idle(1);
        buttons = 2'b10;
        send(1, 8'h03);
        send(0, 8'h00); chk(K_DOUT, 0, 32'h02, 1, "buttons");
        idle(1);

        // interrupt edge latency, mask, acknowledge
        @(negedge clk);
        int_in = 8'h04;
        chk(K_INTN, 0, 32'h1, 1, "irq_intn_n1");
        chk(K_INTN, 0, 32'h0, 2, "irq_intn_n2");
        idle(3);
        send(1, 8'h06);
        send(0, 8'h00); chk(K_INTN, 0, 32'h1, 1, "irq_masked");
        send(1, 8'h06);
        send(0, 8'hFF); chk(K_INTN, 0, 32'h0, 1, "irq_unmasked");
        send(1, 8'h05);
        send(0, 8'h04);
        chk(K_DOUT, 0, 32'h04, 1, "ack_reply");
        chk(K_ACK, 0, 32'h04, 1, "ack_pulse");
        chk(K_INTN, 0, 32'h1, 1, "ack_intn_high");
        idle(1);
        chk(K_ACK, 0, 32'h00, 1, "ack_pulse_end");

        // acknowledge racing a new edge on the same channel
        send(1, 8'h05);
        @(negedge clk);
        data_in_strobe = 1'b0;
        int_in = 8'h06;
        send(0, 8'h02);
        chk(K_DOUT, 0, 32'h00, 1, "race_reply");
        chk(K_INTN, 0, 32'h0, 1, "race_intn_low");
        idle(1);
        send(1, 8'h05);
        send(0, 8'h00); chk(K_DOUT, 0, 32'h02, 1, "race_still_pending");
        idle(1);
        send(1, 8'h05);
        send(0, 8'h02);
        chk(K_ACK, 0, 32'h02, 1, "race_ack_later");
        chk(K_INTN, 0, 32'h1, 1, "race_intn_cleared");
        idle(1);

        // reset in the middle of a config write
        send(1, 8'h04);
        send(0, 8'h03);
        send(0, 8'h77);
        chk(K_REG, 3, 32'h77, 1, "mid_wr_reg3");
        chk(K_STB, 0, 32'h0008, 1, "mid_wr_stb3");
        @(negedge clk);
        data_in_strobe = 1'b0;
        int_in = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(0, 8'h03); chk(K_STB, 0, 32'h0, 1, "post_rst_stb_a");
        send(0, 8'h99); chk(K_STB, 0, 32'h0, 1, "post_rst_stb_b");
        send(0, 8'h88); chk(K_STB, 0, 32'h0, 1, "post_rst_stb_c");
        idle(1);
        chk(K_REG, 3, 32'h33, 1, "post_rst_reg3");
        chk(K_REG, 4, 32'h00, 1, "post_rst_reg4");
        chk(K_REG, 0, 32'h5A, 1, "post_rst_reg0");
        chk(K_LEDS, 0, 32'h0, 1, "post_rst_leds");
        chk(K_COLOR, 0, 32'h0, 1, "post_rst_color");
        chk(K_DOUT, 0, 32'h00, 1, "post_rst_dout");
        chk(K_INTN, 0, 32'h1, 1, "post_rst_intn");
        idle(4);

        if (sb.size() != 0) begin
            tests  += sb.size();
            failed += sb.size();
            $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sysctrl_gen.md
# sysctrl_gen

Parametrised system-control endpoint between the MCU byte-stream link and the core. It decodes framed command bytes into LED/colour control, button readback, a generic indexed config register file, and an edge-latched, maskable interrupt controller, replacing per-core hardwired config variables with `NUM_CFG` indexed 8-bit registers.

## Interface
- `CORE_ID`, 8'h01, core identifier returned by the status command
- `NUM_LEDS`, 2, MCU-controlled LEDs (1..8)
- `NUM_BUTTONS`, 2, button inputs (1..8)
- `NUM_INT`, 8, interrupt channels (1..8)
- `NUM_CFG`, 16, config registers (1..255), 8 bits each
- `CFG_DEFAULT`, all zero, `NUM_CFG*8` bits; reset value of each config register, index i at bits [8i+7:8i]

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `data_in_strobe`  in  1  one-cycle byte-valid pulse
- `data_in_start`  in  1  with strobe: byte is a command code (frame start)
- `data_in`  in  8  byte from MCU
- `data_out`  out  8  reply byte to MCU
- `int_out_n`  out  1  active-low interrupt request to MCU
- `int_in`  in  NUM_INT  interrupt sources, active-high levels
- `int_ack`  out  NUM_INT  one-cycle acknowledge pulse per channel
- `buttons`  in  NUM_BUTTONS  button levels
- `leds`  out  NUM_LEDS  LED drive
- `color`  out  24  RGB value for e.g. ws2812
- `cfg_values`  out  NUM_CFG*8  flat config register bus
- `cfg_strobe`  out  NUM_CFG  one-cycle pulse on each write to register i

## Operation
- Frame: start byte loads `command`, sets byte counter `cnt` to 1. Each later strobe processes the byte at position `cnt`, then increments; `cnt` saturates at 255. Non-start bytes with `cnt`=0 (after reset, before any start) are ignored.
- Cmd 0 status: pos 1/2/3/4 -> `data_out` = 8'h5C / 8'h42 / CORE_ID / NUM_CFG.
- Cmd 1 LEDs: pos 1 -> `leds` = data_in[NUM_LEDS-1:0].
- Cmd 2 colour: bytes are bit-reversed; pos 1 -> color[15:8], pos 2 -> color[7:0], pos 3 -> color[23:16].
- Cmd 3 buttons: every byte -> `data_out` = zero-extended `buttons`.
- Cmd 4 config write: pos 1 loads index register `idx`; pos ≥2 writes data_in to reg[idx], pulses `cfg_strobe[idx]`, then idx+1 (auto-increment burst). Writes with idx ≥ NUM_CFG are dropped with no strobe; idx saturates at 255.
- Cmd 5 interrupt ack: every byte -> `data_out` = pending (zero-extended); pos 1 -> clears pending bits set in data_in, pulses `int_ack` for those bits.
- Cmd 6 interrupt mask: pos 1 -> `mask` = data_in[NUM_INT-1:0].
- Cmd 7 config read: pos 1 loads `idx`; pos ≥2 -> `data_out` = reg[idx] (8'h00 if idx ≥ NUM_CFG), then idx+1.
- Unknown commands: bytes consumed, no effect, `data_out` unchanged.
- Interrupts: `int_in` registered once; rising edge sets pending bit. Set and ack-clear in the same cycle: set wins. `int_out_n` = ~|(pending & mask).

## Timing
- All outputs registered except `int_out_n` (combinational from pending/mask regs).
- `data_out` updates in the cycle after the strobe and holds until the next reply-producing strobe.
- Edge on `int_in` at cycle n -> pending at n+2 -> `int_out_n` low in cycle n+2.
- `cfg_strobe`/`int_ack`: high exactly one cycle, the cycle after the strobe.
- Back-to-back strobes (every cycle) supported at full rate.
- Reset: leds 0, color 0, regs = CFG_DEFAULT, cfg_strobe 0, pending 0, mask all-ones, int_ack 0, data_out 0, cnt 0, idx 0. Reset mid-frame aborts the frame; following non-start bytes are ignored.

## Structure
- Package `sysctrl_pkg`: command codes (CMD_STATUS..CMD_CFG_RD), magic bytes 8'h5C/8'h42, counter/index widths.
- Sub-module `sysctrl_irq` (parameter NUM_INT): edge detect, pending, mask, ack and `int_out_n`; the frame decoder drives its ack/mask write ports.

## Test plan
- Reset, then cmd 0 plus 4 bytes -> data_out 5C, 42, CORE_ID, NUM_CFG (8'h10).
- Cmd 4, bytes 03, AA, BB, CC -> regs 3/4/5 = AA/BB/CC, cfg_strobe bits 3, 4, 5 each pulse once; cmd 7, 03 + 3 reads return AA, BB, CC.
- Cmd 4, idx 8'h0F, values 11, 22 with NUM_CFG=16 -> reg15 = 11, second write dropped, no strobe; cmd 7 at idx 8'h10 -> 00.
- Cmd 2, bytes 01, 02, 80 -> color = 24'h018040.
- int_in[2] rises -> int_out_n low 2 cycles later; cmd 6 mask 00 -> high; mask FF, cmd 5 + byte 04 -> reply 04, int_ack[2] pulse, int_out_n high.
- Ack bit 1 in the same cycle int_in[1] pending set -> bit stays pending; reset mid-cmd 4 -> following data bytes ignored, regs at defaults.
